// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and a full
// freeze while a D-cache miss is outstanding, plus debug counters.
module hazard_stall_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             MemToRegE,
  input  logic [2:0]       RegWriteE,
  input  logic             JalD,
  input  logic             JalrE,
  input  logic             BranchTakenE,
  input  logic             DMissM,
  input  logic             DAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             MemWait,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] MissCnt,
  output logic             TimeoutErr
);

  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          load_use, redirect;
  logic          miss_inc, to_set, wait_run;

  assign load_use = MemToRegE && (RegWriteE != 3'd0) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign redirect = BranchTakenE || JalrE;
  assign MemWait  = (state == MEM_WAIT);

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;
    state_nxt = state;
    miss_inc  = 1'b0;
    to_set    = 1'b0;
    wait_run  = 1'b0;
    case (state)
      RUN: begin
        if (DMissM) begin
          {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
          state_nxt = MEM_WAIT;
          miss_inc  = 1'b1;
        end else if (redirect) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (JalD) begin
          FlushD = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (DAckM && !DMissM) begin
          // Release cycle: the pipeline advances, so only the flushes apply.
          state_nxt = RUN;
          if (redirect) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (load_use) begin
            FlushE = 1'b1;
          end else if (JalD) begin
            FlushD = 1'b1;
          end
        end else begin
          {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
          if (DAckM && DMissM) begin
            // Back-to-back miss restarts the wait window for the new access.
            miss_inc = 1'b1;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            to_set    = 1'b1;
            state_nxt = RUN;
          end else begin
            wait_run = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      StallCnt   <= '0;
      MissCnt    <= '0;
      TimeoutErr <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_run ? wait_cnt + 1'b1 : '0;
      if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + 1'b1;
      if (miss_inc && (MissCnt != '1)) MissCnt <= MissCnt + 1'b1;
      if (to_set) TimeoutErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, redirect, miss freeze,
// back-to-back miss, timeout and async reset during a wait.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        MemToRegE;
  logic [2:0]  RegWriteE;
  logic        JalD, JalrE, BranchTakenE, DMissM, DAckM;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic        MemWait, TimeoutErr;
  logic [31:0] StallCnt, MissCnt;

  int vectors = 0;
  int errors  = 0;
  int exp_sc  = 0;
  int exp_mc  = 0;

  hazard_stall_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemToRegE(MemToRegE), .RegWriteE(RegWriteE), .JalD(JalD), .JalrE(JalrE),
    .BranchTakenE(BranchTakenE), .DMissM(DMissM), .DAckM(DAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MemWait(MemWait), .StallCnt(StallCnt), .MissCnt(MissCnt), .TimeoutErr(TimeoutErr)
  );

  always #5 clk = ~clk;

  wire [4:0] stalls  = {StallF, StallD, StallE, StallM, StallW};
  wire [3:0] flushes = {FlushD, FlushE, FlushM, FlushW};

  task automatic clr_in();
    Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0; MemToRegE = 1'b0; RegWriteE = 3'd0;
    JalD = 1'b0; JalrE = 1'b0; BranchTakenE = 1'b0; DMissM = 1'b0; DAckM = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [2:0] rw);
    MemToRegE = 1'b1; RdE = rd; Rs1D = r1; Rs2D = r2; RegWriteE = rw;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_in();
    #12;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b0) begin errors++;
      $display("FAIL rst_outputs stall=%b flush=%b want 00000/0000", stalls, flushes); end
    vectors++; if (MemWait !== 1'b0 || TimeoutErr !== 1'b0) begin errors++;
      $display("FAIL rst_flags memwait=%b to=%b want 0/0", MemWait, TimeoutErr); end
    vectors++; if (StallCnt !== 32'd0 || MissCnt !== 32'd0) begin errors++;
      $display("FAIL rst_cnts sc=%0d mc=%0d want 0/0", StallCnt, MissCnt); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk); clr_in(); set_lu(5'd5, 5'd5, 5'd7, 3'd2); #1;
    vectors++; if (stalls !== 5'b11000 || flushes !== 4'b0100) begin errors++;
      $display("FAIL lu_rs1 stall=%b flush=%b want 11000/0100", stalls, flushes); end
    exp_sc++; tick();
    vectors++; if (StallCnt !== 32'(exp_sc)) begin errors++;
      $display("FAIL lu_stallcnt got %0d want %0d", StallCnt, exp_sc); end
    @(negedge clk); set_lu(5'd5, 5'd3, 5'd5, 3'd1); #1;
    vectors++; if (stalls !== 5'b11000 || flushes !== 4'b0100) begin errors++;
      $display("FAIL lu_rs2 stall=%b flush=%b want 11000/0100", stalls, flushes); end
    exp_sc++; tick();
  endtask

  task automatic test_no_stall();
    @(negedge clk); clr_in(); set_lu(5'd0, 5'd0, 5'd0, 3'd2); #1;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b0) begin errors++;
      $display("FAIL ns_rd0 stall=%b flush=%b want 0", stalls, flushes); end
    @(negedge clk); set_lu(5'd5, 5'd5, 5'd0, 3'd0); #1;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b0) begin errors++;
      $display("FAIL ns_rw0 stall=%b flush=%b want 0", stalls, flushes); end
    @(negedge clk); set_lu(5'd5, 5'd5, 5'd0, 3'd2); MemToRegE = 1'b0; #1;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b0) begin errors++;
      $display("FAIL ns_notload stall=%b flush=%b want 0", stalls, flushes); end
    tick();
    vectors++; if (StallCnt !== 32'(exp_sc)) begin errors++;
      $display("FAIL ns_stallcnt got %0d want %0d", StallCnt, exp_sc); end
  endtask

  task automatic test_redirect();
    @(negedge clk); clr_in(); set_lu(5'd5, 5'd5, 5'd0, 3'd2); BranchTakenE = 1'b1; #1;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b1100) begin errors++;
      $display("FAIL rd_branch_lu stall=%b flush=%b want 00000/1100", stalls, flushes); end
    @(negedge clk); BranchTakenE = 1'b0; JalrE = 1'b1; JalD = 1'b1; #1;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b1100) begin errors++;
      $display("FAIL rd_jalr stall=%b flush=%b want 00000/1100", stalls, flushes); end
    @(negedge clk); clr_in(); JalD = 1'b1; #1;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b1000) begin errors++;
      $display("FAIL rd_jal stall=%b flush=%b want 00000/1000", stalls, flushes); end
    tick();
  endtask

  task automatic test_miss();
    @(negedge clk); clr_in(); set_lu(5'd5, 5'd5, 5'd0, 3'd2); DMissM = 1'b1; #1;
    vectors++; if (stalls !== 5'b11111 || flushes !== 4'b0 || MemWait !== 1'b0) begin errors++;
      $display("FAIL miss_t0 stall=%b flush=%b mw=%b want 11111/0000/0", stalls, flushes, MemWait); end
    exp_sc++; exp_mc++; tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); DMissM = 1'b0; #1;
      vectors++; if (stalls !== 5'b11111 || flushes !== 4'b0 || MemWait !== 1'b1) begin errors++;
        $display("FAIL miss_wait%0d stall=%b flush=%b mw=%b want 11111/0000/1", i, stalls, flushes, MemWait); end
      exp_sc++; tick();
    end
    @(negedge clk); DAckM = 1'b1; BranchTakenE = 1'b1; #1;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b1100 || MemWait !== 1'b1) begin errors++;
      $display("FAIL miss_ack stall=%b flush=%b mw=%b want 00000/1100/1", stalls, flushes, MemWait); end
    tick();
    vectors++; if (MemWait !== 1'b0 || MissCnt !== 32'(exp_mc) || StallCnt !== 32'(exp_sc)) begin errors++;
      $display("FAIL miss_after mw=%b mc=%0d sc=%0d want 0/%0d/%0d", MemWait, MissCnt, StallCnt, exp_mc, exp_sc); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); clr_in(); DMissM = 1'b1;
    exp_sc++; exp_mc++; tick();
    @(negedge clk); DMissM = 1'b0; exp_sc++; tick();
    @(negedge clk); DMissM = 1'b1; DAckM = 1'b1; #1;
    vectors++; if (stalls !== 5'b11111 || flushes !== 4'b0) begin errors++;
      $display("FAIL b2b_stall stall=%b flush=%b want 11111/0000", stalls, flushes); end
    exp_sc++; exp_mc++; tick();
    vectors++; if (MemWait !== 1'b1 || MissCnt !== 32'(exp_mc)) begin errors++;
      $display("FAIL b2b_cnt mw=%b mc=%0d want 1/%0d", MemWait, MissCnt, exp_mc); end
    @(negedge clk); DAckM = 1'b0; DMissM = 1'b1; exp_sc++; tick();
    vectors++; if (MemWait !== 1'b1 || MissCnt !== 32'(exp_mc)) begin errors++;
      $display("FAIL b2b_ignored mw=%b mc=%0d want 1/%0d", MemWait, MissCnt, exp_mc); end
    @(negedge clk); DMissM = 1'b0; DAckM = 1'b1; set_lu(5'd9, 5'd0, 5'd9, 3'd4); #1;
    vectors++; if (stalls !== 5'b0 || flushes !== 4'b0100) begin errors++;
      $display("FAIL b2b_ack_lu stall=%b flush=%b want 00000/0100", stalls, flushes); end
    tick();
    vectors++; if (MemWait !== 1'b0 || StallCnt !== 32'(exp_sc)) begin errors++;
      $display("FAIL b2b_after mw=%b sc=%0d want 0/%0d", MemWait, StallCnt, exp_sc); end
  endtask

  task automatic test_timeout();
    @(negedge clk); clr_in(); DMissM = 1'b1;
    exp_sc++; exp_mc++; tick();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); DMissM = 1'b0; #1;
      vectors++; if (MemWait !== 1'b1 || TimeoutErr !== 1'b0 || StallF !== 1'b1) begin errors++;
        $display("FAIL to_wait%0d mw=%b to=%b sf=%b want 1/0/1", k, MemWait, TimeoutErr, StallF); end
      exp_sc++; tick();
    end
    vectors++; if (TimeoutErr !== 1'b1 || MemWait !== 1'b0) begin errors++;
      $display("FAIL to_set to=%b mw=%b want 1/0", TimeoutErr, MemWait); end
    vectors++; if (StallCnt !== 32'(exp_sc) || MissCnt !== 32'(exp_mc)) begin errors++;
      $display("FAIL to_cnts sc=%0d mc=%0d want %0d/%0d", StallCnt, MissCnt, exp_sc, exp_mc); end
    @(negedge clk); #1;
    vectors++; if (stalls !== 5'b0 || TimeoutErr !== 1'b1) begin errors++;
      $display("FAIL to_run stall=%b to=%b want 00000/1", stalls, TimeoutErr); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk); clr_in(); DMissM = 1'b1; tick();
    @(negedge clk); DMissM = 1'b0; tick(); tick();
    #2 rst_n = 1'b0; #1;
    vectors++; if (MemWait !== 1'b0 || stalls !== 5'b0) begin errors++;
      $display("FAIL rmw_release mw=%b stall=%b want 0/00000", MemWait, stalls); end
    vectors++; if (StallCnt !== 32'd0 || MissCnt !== 32'd0 || TimeoutErr !== 1'b0) begin errors++;
      $display("FAIL rmw_cnts sc=%0d mc=%0d to=%b want 0/0/0", StallCnt, MissCnt, TimeoutErr); end
    @(negedge clk); rst_n = 1'b1; tick();
    vectors++; if (MemWait !== 1'b0 || StallCnt !== 32'd0) begin errors++;
      $display("FAIL rmw_after mw=%b sc=%0d want 0/0", MemWait, StallCnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect();
    test_miss();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
